// File: rtl/axi4lite_master.sv
// AXI4-Lite master: one outstanding register read/write per command.
// Define AXI4L_MASTER_TIMEOUT_EN to abort stalled transactions with resp 2'b11.
module axi4lite_master #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    axi4l_aclk,
   input  logic                    axi4l_areset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    axi4l_awvalid,
   input  logic                    axi4l_awready,
   output logic [ADDR_WIDTH-1:0]   axi4l_awaddr,
   output logic [2:0]              axi4l_awprot,
   output logic                    axi4l_wvalid,
   input  logic                    axi4l_wready,
   output logic [DATA_WIDTH-1:0]   axi4l_wdata,
   output logic [DATA_WIDTH/8-1:0] axi4l_wstrb,
   input  logic                    axi4l_bvalid,
   output logic                    axi4l_bready,
   input  logic [1:0]              axi4l_bresp,
   output logic                    axi4l_arvalid,
   input  logic                    axi4l_arready,
   output logic [ADDR_WIDTH-1:0]   axi4l_araddr,
   output logic [2:0]              axi4l_arprot,
   input  logic                    axi4l_rvalid,
   output logic                    axi4l_rready,
   input  logic [DATA_WIDTH-1:0]   axi4l_rdata,
   input  logic [1:0]              axi4l_rresp
);

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_WR_ADDR_DATA = 3'd1;
   localparam logic [2:0] S_WR_RESP      = 3'd2;
   localparam logic [2:0] S_RD_ADDR      = 3'd3;
   localparam logic [2:0] S_RD_DATA      = 3'd4;
   localparam logic [2:0] S_RSP          = 3'd5;

   logic [2:0]            r_state;
   logic                  r_cmd_ready;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic                  r_bready;
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic [1:0]            r_rsp_resp;

   logic w_accept;
   logic w_busy;
   logic w_progress;
   logic w_timeout;
   logic w_abort;

   assign w_accept = (r_state == S_IDLE) & r_cmd_ready & cmd_valid;
   assign w_busy   = (r_state == S_WR_ADDR_DATA) | (r_state == S_WR_RESP) |
                     (r_state == S_RD_ADDR) | (r_state == S_RD_DATA);

   // A phase that completes on the timeout edge wins over the abort.
   always_comb begin
      w_progress = 1'b0;
      case (r_state)
         S_WR_ADDR_DATA: w_progress = r_aw_done & r_w_done;
         S_WR_RESP:      w_progress = axi4l_bvalid;
         S_RD_ADDR:      w_progress = axi4l_arready;
         S_RD_DATA:      w_progress = axi4l_rvalid;
         default:        w_progress = 1'b0;
      endcase
   end

`ifdef AXI4L_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge axi4l_aclk) begin
      if (axi4l_areset || r_state == S_IDLE) begin
         r_cnt <= '0;
      end else if (w_busy) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign w_timeout = w_busy & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   assign w_abort = w_timeout & ~w_progress;

   always_ff @(posedge axi4l_aclk) begin
      if (axi4l_areset) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (w_accept) begin
                  r_cmd_ready <= 1'b0;
                  r_addr      <= cmd_addr;
                  r_wdata     <= cmd_wdata;
                  if (cmd_write) begin
                     r_state   <= S_WR_ADDR_DATA;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_aw_done <= 1'b0;
                     r_w_done  <= 1'b0;
                  end else begin
                     r_state   <= S_RD_ADDR;
                     r_arvalid <= 1'b1;
                  end
               end
            end
            S_WR_ADDR_DATA: begin
               if (r_aw_done && r_w_done) begin
                  r_state  <= S_WR_RESP;
                  r_bready <= 1'b1;
               end else begin
                  if (r_awvalid && axi4l_awready) begin
                     r_awvalid <= 1'b0;
                     r_aw_done <= 1'b1;
                  end
                  if (r_wvalid && axi4l_wready) begin
                     r_wvalid <= 1'b0;
                     r_w_done <= 1'b1;
                  end
               end
            end
            S_WR_RESP: begin
               if (axi4l_bvalid) begin
                  r_bready    <= 1'b0;
                  r_rsp_resp  <= axi4l_bresp;
                  r_rsp_rdata <= '0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RSP;
               end
            end
            S_RD_ADDR: begin
               if (axi4l_arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (axi4l_rvalid) begin
                  r_rready    <= 1'b0;
                  r_rsp_rdata <= axi4l_rdata;
                  r_rsp_resp  <= axi4l_rresp;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RSP;
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
         if (w_abort) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_resp  <= 2'b11;
            r_rsp_rdata <= '0;
            r_state     <= S_RSP;
         end
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_resp      = r_rsp_resp;
   assign axi4l_awvalid = r_awvalid;
   assign axi4l_awaddr  = r_addr;
   assign axi4l_awprot  = 3'b000;
   assign axi4l_wvalid  = r_wvalid;
   assign axi4l_wdata   = r_wdata;
   assign axi4l_wstrb   = '1;
   assign axi4l_bready  = r_bready;
   assign axi4l_arvalid = r_arvalid;
   assign axi4l_araddr  = r_addr;
   assign axi4l_arprot  = 3'b000;
   assign axi4l_rready  = r_rready;

endmodule

// File: tb/tb_axi4lite_master.sv
// Bench for axi4lite_master: random commands against a reference register
// map, behavioural AXI slave with programmable wait states, queued checks.
module tb_axi4lite_master;

   localparam int AW = 8;
   localparam int DW = 32;
`ifdef AXI4L_MASTER_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 255;
`endif

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic [1:0]    resp;
   } exp_t;

   logic          clk       = 1'b0;
   logic          areset    = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr  = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          awvalid;
   logic          awready = 1'b0;
   logic [AW-1:0] awaddr;
   logic [2:0]    awprot;
   logic          wvalid;
   logic          wready = 1'b0;
   logic [DW-1:0] wdata;
   logic [3:0]    wstrb;
   logic          bvalid = 1'b0;
   logic          bready;
   logic [1:0]    bresp = 2'b00;
   logic          arvalid;
   logic          arready = 1'b0;
   logic [AW-1:0] araddr;
   logic [2:0]    arprot;
   logic          rvalid = 1'b0;
   logic          rready;
   logic [DW-1:0] rdata = '0;
   logic [1:0]    rresp = 2'b00;

   axi4lite_master #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .axi4l_aclk(clk),
      .axi4l_areset(areset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp),
      .axi4l_awvalid(awvalid),
      .axi4l_awready(awready),
      .axi4l_awaddr(awaddr),
      .axi4l_awprot(awprot),
      .axi4l_wvalid(wvalid),
      .axi4l_wready(wready),
      .axi4l_wdata(wdata),
      .axi4l_wstrb(wstrb),
      .axi4l_bvalid(bvalid),
      .axi4l_bready(bready),
      .axi4l_bresp(bresp),
      .axi4l_arvalid(arvalid),
      .axi4l_arready(arready),
      .axi4l_araddr(araddr),
      .axi4l_arprot(arprot),
      .axi4l_rvalid(rvalid),
      .axi4l_rready(rready),
      .axi4l_rdata(rdata),
      .axi4l_rresp(rresp)
   );

   initial forever #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   exp_t sbq[$];
   logic [DW-1:0] smem[256];
   logic [DW-1:0] rmem[256];

   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   bit rr_force = 1'b1;
   bit rr_val   = 1'b1;

   int cyc = 0, acc_cyc = 0, rise_cyc = 0, hs_cyc = 0;
   int rsp_cnt = 0, issued = 0, abandoned = 0;
   int wo_cnt = 0, arv_cnt = 0, ar_hs = 0, b_hs = 0;
   int hold_n = 0, hold_max = 0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_wdata = '0;

   function automatic logic [1:0] resp_of(input logic [AW-1:0] a);
      return (a[7:5] == 3'b111) ? 2'b10 : 2'b00;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural slave: decisions made on the falling edge take effect
   // at the following rising edge.
   bit aw_got, w_got, aw_pend, w_pend, b_done;
   bit ar_got, ar_pend, r_done;
   int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   logic [AW-1:0] waddr, raddr;
   logic [DW-1:0] wdat;

   always @(negedge clk) begin
      if (areset) begin
         awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
         aw_got = 0; w_got = 0; aw_pend = 0; w_pend = 0; b_done = 0;
         ar_got = 0; ar_pend = 0; r_done = 0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
         if (b_done) begin
            bvalid = 0; b_done = 0; aw_got = 0; w_got = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         end else begin
            if (!bvalid && aw_got && w_got) begin
               if (b_cnt >= b_dly) begin
                  bvalid = 1; bresp = resp_of(waddr);
               end else b_cnt++;
            end
            if (bvalid && bready) begin
               b_done = 1; b_hs++; smem[waddr] = wdat;
            end
         end
         if (aw_pend) begin
            aw_pend = 0; awready = 0;
            chk("awvalid_drop", awvalid, 0);
         end else if (awvalid && !aw_got) begin
            if (aw_cnt >= aw_dly) begin
               awready = 1; aw_got = 1; aw_pend = 1; waddr = awaddr;
               chk("awaddr", awaddr, exp_addr);
               chk("awprot", awprot, 0);
            end else aw_cnt++;
         end
         if (w_pend) begin
            w_pend = 0; wready = 0;
            chk("wvalid_drop", wvalid, 0);
         end else if (wvalid && !w_got) begin
            if (w_cnt >= w_dly) begin
               wready = 1; w_got = 1; w_pend = 1; wdat = wdata;
               chk("wdata", wdata, exp_wdata);
               chk("wstrb", wstrb, 4'hF);
            end else w_cnt++;
         end
         if (r_done) begin
            rvalid = 0; r_done = 0; ar_got = 0; ar_cnt = 0; r_cnt = 0;
         end else begin
            if (!rvalid && ar_got) begin
               if (r_cnt >= r_dly) begin
                  rvalid = 1; rdata = smem[raddr]; rresp = resp_of(raddr);
               end else r_cnt++;
            end
            if (rvalid && rready) r_done = 1;
         end
         if (ar_pend) begin
            ar_pend = 0; arready = 0;
            chk("arvalid_drop", arvalid, 0);
         end else if (arvalid && !ar_got) begin
            if (ar_cnt >= ar_dly) begin
               arready = 1; ar_got = 1; ar_pend = 1; raddr = araddr; ar_hs++;
               chk("araddr", araddr, exp_addr);
               chk("arprot", arprot, 0);
            end else ar_cnt++;
         end
      end
   end

   // Response monitor and scoreboard.
   bit prev_rv = 0, held = 0;
   logic [DW-1:0] hd;
   logic [1:0] hr;
   exp_t mon_e;

   always @(negedge clk) begin
      cyc++;
      if (areset) begin
         held = 0; prev_rv = 0; hold_n = 0;
      end else begin
         if (cmd_valid && cmd_ready) begin
            acc_cyc = cyc; exp_addr = cmd_addr; exp_wdata = cmd_wdata;
         end
         if (!wvalid && awvalid) wo_cnt++;
         if (arvalid) arv_cnt++;
         if (rsp_valid) begin
            if (!prev_rv) rise_cyc = cyc;
            chk("cmd_ready_in_rsp", cmd_ready, 0);
            if (held) begin
               chk("rsp_rdata_stable", rsp_rdata, hd);
               chk("rsp_resp_stable", rsp_resp, hr);
            end
            if (rsp_ready) begin
               hs_cyc = cyc; rsp_cnt++; held = 0; hold_n = 0;
               if (sbq.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_rsp: got rdata 0x%0h, expected none",
                           rsp_rdata);
               end else begin
                  mon_e = sbq.pop_front();
                  chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                  chk("rsp_resp", rsp_resp, mon_e.resp);
               end
            end else begin
               held = 1; hd = rsp_rdata; hr = rsp_resp;
               hold_n++;
               if (hold_n > hold_max) hold_max = hold_n;
            end
         end else begin
            held = 0; hold_n = 0;
         end
         prev_rv = rsp_valid;
      end
   end

   initial forever begin
      @(posedge clk); #1;
      rsp_ready = rr_force ? rr_val : ($urandom_range(0, 2) != 0);
   end

   task automatic issue(input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit to_exp);
      exp_t e;
      int n;
      @(posedge clk); #1;
      cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      if (to_exp) begin
         e.rdata = '0; e.resp = 2'b11;
      end else if (wr) begin
         e.rdata = '0; e.resp = resp_of(a); rmem[a] = d;
      end else begin
         e.rdata = rmem[a]; e.resp = resp_of(a);
      end
      sbq.push_back(e);
      issued++;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 3000) begin
         @(negedge clk); n++;
      end
      if (!cmd_ready) begin
         tests++; fails++;
         $display("FAIL cmd_accept: cmd_ready 0 after %0d cycles, expected 1", n);
      end
      @(posedge clk); #1;
      cmd_valid = 0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sbq.size() != 0 && n < 5000) begin
         @(negedge clk); n++;
      end
      if (sbq.size() != 0) begin
         tests++; fails++;
         $display("FAIL drain: %0d responses outstanding, expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctl"}, {cmd_ready, rsp_valid, awvalid, wvalid, bready,
                          arvalid, rready, awprot, arprot, rsp_resp}, 0);
      chk({tag, "_data"}, {rsp_rdata, wdata}, 0);
      chk({tag, "_addr"}, {awaddr, araddr}, 0);
   endtask

   task automatic abandon_with_reset();
      exp_t drop;
      @(posedge clk); #1;
      areset = 1;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("midreset");
      if (sbq.size() != 0) drop = sbq.pop_front();
      abandoned++;
      @(posedge clk); #1;
      areset = 0;
      @(negedge clk);
      chk("cmd_ready_release0", cmd_ready, 0);
      @(negedge clk);
      chk("cmd_ready_release1", cmd_ready, 1);
   endtask

   initial begin
      logic [DW-1:0] old;
      int n;
      for (int i = 0; i < 256; i++) begin
         smem[i] = 32'hA5000000 | 32'(i);
         rmem[i] = 32'hA5000000 | 32'(i);
      end
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      areset = 0;
      @(negedge clk);
      chk("cmd_ready_release0", cmd_ready, 0);
      @(negedge clk);
      chk("cmd_ready_release1", cmd_ready, 1);

      issue(1, 8'h00, 32'h1, 0);
      wait_drain();
      chk("wr_latency", 64'(rise_cyc - acc_cyc), 4);
      issue(0, 8'h00, '0, 0);
      wait_drain();
      chk("rd_latency", 64'(rise_cyc - acc_cyc), 3);

      smem[6] = 32'hB9; rmem[6] = 32'hB9;
      r_dly = 5;
      n = ar_hs;
      issue(0, 8'h06, '0, 0);
      wait_drain();
      chk("ar_handshakes", 64'(ar_hs - n), 1);
      r_dly = 0;

      aw_dly = 3; wo_cnt = 0; n = b_hs;
      issue(1, 8'h10, 32'hDEADBEEF, 0);
      wait_drain();
      chk("w_before_aw_cycles", 64'(wo_cnt), 3);
      chk("b_handshakes", 64'(b_hs - n), 1);
      aw_dly = 0;

      rr_val = 0; hold_max = 0;
      issue(0, 8'h10, '0, 0);
      fork
         begin
            repeat (14) @(posedge clk);
            rr_val = 1;
         end
         issue(1, 8'h21, 32'h0BADF00D, 0);
      join
      chk("accept_after_rsp_hs", 64'(acc_cyc - hs_cyc), 1);
      chk("rsp_hold_ge10", 64'(hold_max >= 10), 1);
      wait_drain();

      rr_force = 0;
      repeat (80) begin
         logic [AW-1:0] a;
         aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
         b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
         r_dly = $urandom_range(0, 4);
         a = ($urandom_range(0, 3) == 0) ? AW'(8'hE0 | $urandom_range(0, 3))
                                         : AW'($urandom_range(0, 15));
         issue(1'($urandom_range(0, 1)), a, $urandom, 0);
      end
      wait_drain();
      rr_force = 1; rr_val = 1;
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

`ifdef AXI4L_MASTER_TIMEOUT_EN
      ar_dly = 1000000; arv_cnt = 0;
      issue(0, 8'h30, '0, 1);
      wait_drain();
      chk("timeout_arvalid_cycles", 64'(arv_cnt), 16);
      ar_dly = 0;
`else
      ar_dly = 1000000;
      issue(0, 8'h30, '0, 0);
      repeat (1000) @(negedge clk);
      chk("hang_arvalid_1000", arvalid, 1);
      abandon_with_reset();
      ar_dly = 0;
`endif

      b_dly = 20;
      old = rmem[8'h44];
      issue(1, 8'h44, 32'h12345678, 0);
      n = 0;
      while (!bready && n < 100) begin
         @(negedge clk); n++;
      end
      chk("reached_wr_resp", bready, 1);
      abandon_with_reset();
      rmem[8'h44] = old;
      b_dly = 0;
      issue(0, 8'h44, '0, 0);
      wait_drain();

      repeat (5) @(negedge clk);
      chk("rsp_count", 64'(rsp_cnt), 64'(issued - abandoned));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/axi4lite_master.md
AXI4LITE_MASTER -- requirements
Module: axi4lite_master

Interface
REQ-001 ADDR_WIDTH, default 8, width of cmd_addr, axi4l_awaddr and axi4l_araddr.
REQ-002 DATA_WIDTH, default 32, width of every data bus; axi4l_wstrb is DATA_WIDTH/8 bits.
REQ-003 TIMEOUT_CYCLES, default 255, maximum cycles a transaction waits for the slave.
REQ-004 axi4l_aclk  in  1  single clock; all logic rising-edge.
REQ-005 axi4l_areset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-008 cmd_write  in  1  1 = register write, 0 = register read.
REQ-009 cmd_addr  in  ADDR_WIDTH  register address.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
REQ-013 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-014 rsp_resp  out  2  BRESP/RRESP from the slave, or 2'b11 on timeout.
REQ-015 axi4l_awvalid/awready/awaddr/awprot  out/in/out/out  1/1/ADDR_WIDTH/3  write-address channel.
REQ-016 axi4l_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  write-data channel.
REQ-017 axi4l_bvalid/bready/bresp  in/out/in  1/1/2  write-response channel.
REQ-018 axi4l_arvalid/arready/araddr/arprot  out/in/out/out  1/1/ADDR_WIDTH/3  read-address channel.
REQ-019 axi4l_rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_WIDTH/2  read-data channel.

Function
REQ-020 FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP; one transaction outstanding at a time.
REQ-021 cmd_ready = 1 only in IDLE; on accept, cmd_addr and cmd_wdata are registered, and the FSM enters WR_ADDR_DATA (write) or RD_ADDR (read) on the next cycle.
REQ-022 WR_ADDR_DATA: awvalid and wvalid rise together; each drops the cycle after its own handshake, in either order or simultaneously; the FSM moves to WR_RESP once both handshakes are done.
REQ-023 WR_RESP: bready = 1; on bvalid, capture bresp, set rsp_rdata = 0, go to RSP. RD_ADDR: arvalid held until arready, then RD_DATA.
REQ-024 RD_DATA: rready = 1; on rvalid, capture rdata and rresp, go to RSP.
REQ-025 RSP: rsp_valid held with stable payload until rsp_ready, then IDLE; a new command is accepted no earlier than the cycle after the response handshake.
REQ-026 awprot = arprot = 3'b000 and wstrb = all ones, always.
REQ-027 Valid signals never depend combinationally on ready inputs; all AXI outputs are registered.
REQ-028 Minimum latency: with the slave ready immediately, rsp_valid asserts 3 cycles after cmd accept for a read and 4 cycles for a write.

Reset
REQ-029 While axi4l_areset = 1 at a clock edge, the FSM goes to IDLE and all outputs go to 0 except cmd_ready; cmd_ready is 0 during reset and rises to 1 the first cycle after reset is released. A reset mid-transaction abandons that transaction with no response.

Configuration
REQ-030 With AXI4L_MASTER_TIMEOUT_EN defined, a cycle counter clears on cmd accept and counts in the WR_ADDR_DATA, WR_RESP, RD_ADDR and RD_DATA states; when it reaches TIMEOUT_CYCLES, all AXI valids and readies drop and the FSM enters RSP with rsp_resp = 2'b11 and rsp_rdata = 0.
REQ-031 Without AXI4L_MASTER_TIMEOUT_EN, no counter exists and the block waits indefinitely for the slave.

Verification
REQ-032 Write addr 0x00, data 0x1, with awready, wready and bvalid immediate and bresp = 00 -> rsp_valid 4 cycles after accept, rsp_resp = 00, awaddr = 0x00, wdata = 0x1, wstrb = 0xF.
REQ-033 Read addr 0x06, with the slave returning 0xB9 after 5 wait cycles on rvalid -> rsp_rdata = 0xB9, rsp_resp = 00, arvalid asserted for exactly one handshake.
REQ-034 Write with wready 3 cycles before awready -> wvalid drops first, awvalid holds, exactly one bready handshake occurs, response OK.
REQ-035 rsp_ready held 0 for 10 cycles -> rsp_valid and its payload stay stable and cmd_ready stays 0; a command accepted on the cycle after the response handshake completes correctly.
REQ-036 With the macro defined and TIMEOUT_CYCLES = 16, arready never asserted -> arvalid drops after 16 cycles, rsp_resp = 11; without the macro, arvalid is still high at cycle 1000.
REQ-037 Reset asserted in WR_RESP -> the next cycle has all outputs 0 and no rsp_valid; after release, a read completes normally.
